fp16_align: RTL

Iterative half-precision operand aligner. It is the inverse of the post-add normalization step: it takes two unpacked fp16 operands, each a 5-bit exponent and a 12-bit mantissa. It right-shifts the mantissa of the smaller-exponent operand one bit per cycle until both exponents match. It sits in front of the fp16 mantissa adder, and its output mantissa format is identical to the normalizer's input format.

---
 rtl/fp16_align_if.sv | 33 +++
 rtl/fp16_align.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp16_align_if.sv
// fp16_align_if: operand and result handshake bundle for fp16_align.
// slave is the aligner side, master is the producer/consumer side.
interface fp16_align_if #(
    parameter int MANT_W = 12,
    parameter int EXP_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant_a;
    logic [EXP_W-1:0]  in_exp_a;
    logic [MANT_W-1:0] in_mant_b;
    logic [EXP_W-1:0]  in_exp_b;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant_a;
    logic [MANT_W-1:0] out_mant_b;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sticky;

    modport slave (
        input  in_valid, in_mant_a, in_exp_a, in_mant_b, in_exp_b,
        input  out_ready,
        output in_ready,
        output out_valid, out_mant_a, out_mant_b, out_exp, out_sticky
    );

    modport master (
        output in_valid, in_mant_a, in_exp_a, in_mant_b, in_exp_b,
        output out_ready,
        input  in_ready,
        input  out_valid, out_mant_a, out_mant_b, out_exp, out_sticky
    );
endinterface

// File: rtl/fp16_align.sv
// fp16_align: iterative fp16 operand aligner, one right shift per cycle.
// Define FP16_ALIGN_STICKY_EN to build the sticky accumulator.
module fp16_align #(
    parameter int MANT_W = 12,
    parameter int EXP_W  = 5
) (
    input  logic         clk,
    input  logic         reset,
    fp16_align_if.slave  bus
);
    localparam int CNT_W = $clog2(MANT_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic              tgt_b;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic [EXP_W-1:0]  exp_q;
    logic              valid_q;

    logic              accept;
    logic              a_small;
    logic [EXP_W-1:0]  diff;
    logic [CNT_W-1:0]  cnt_init;

    assign bus.in_ready = (state == S_IDLE) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign a_small      = bus.in_exp_a < bus.in_exp_b;

    // Exponent distance, clamped so a full-width shift flushes the mantissa
    always_comb begin
        diff     = a_small ? (bus.in_exp_b - bus.in_exp_a)
                           : (bus.in_exp_a - bus.in_exp_b);
        cnt_init = CNT_W'(diff);
        if (int'(diff) >= MANT_W) begin
            cnt_init = CNT_W'(MANT_W);
        end
    end

    // Control FSM and datapath registers; the last shift lands in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            tgt_b   <= 1'b0;
            mant_a  <= '0;
            mant_b  <= '0;
            exp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        mant_a  <= bus.in_mant_a;
                        mant_b  <= bus.in_mant_b;
                        exp_q   <= a_small ? bus.in_exp_b : bus.in_exp_a;
                        count   <= cnt_init;
                        tgt_b   <= !a_small;
                        if (cnt_init != '0) begin
                            state <= S_SHIFT;
                        end else begin
                            state   <= S_DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (tgt_b) begin
                        mant_b <= mant_b >> 1;
                    end else begin
                        mant_a <= mant_a >> 1;
                    end
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state   <= S_DONE;
                        valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_mant_a = mant_a;
    assign bus.out_mant_b = mant_b;
    assign bus.out_exp    = exp_q;

`ifdef FP16_ALIGN_STICKY_EN
    logic sticky_q;
    logic shift_en;
    logic lsb;

    assign shift_en = (state == S_SHIFT);
    assign lsb      = tgt_b ? mant_b[0] : mant_a[0];

    // Collect every bit that falls off the target mantissa
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (accept) begin
            sticky_q <= 1'b0;
        end else if (shift_en) begin
            sticky_q <= sticky_q | lsb;
        end
    end

    assign bus.out_sticky = sticky_q;
`else
    assign bus.out_sticky = 1'b0;
`endif
endmodule
